instr_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, control-unit opcodes and fetch FSM states.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 16;
  localparam int unsigned OPCODE_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry synchronous FIFO with flush and registered head outputs.
// Exposes the next-cycle occupancy so the fetch FSM can register its request decision.
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_n, rd_ptr, rd_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             do_pop;

  // Next-state of storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_n  = mem;
    wr_n   = wr_ptr;
    rd_n   = rd_ptr;
    cnt_n  = cnt;
    do_pop = pop && (cnt != '0);
    if (flush) begin
      wr_n  = '0;
      rd_n  = '0;
      cnt_n = '0;
    end else begin
      if (push) begin
        mem_n[wr_ptr] = push_data;
        wr_n          = wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_n = rd_ptr + PTR_W'(1);
      end
      cnt_n = cnt + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  assign count_nxt_c = cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      mem    <= mem_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      cnt    <= cnt_n;
      valid  <= (cnt_n != '0);
      head   <= mem_n[rd_n];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/gnt/rvalid memory handshake, fetch buffer, branch redirect.
// Optional halt-on-opcode-F behaviour is enabled by defining IFETCH_HALT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        INSTR_W  = INSTR_WIDTH,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [3:0]         id_opcode,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, req_pc, req_pc_n;
  logic              halted_n, req_n;
  logic              push, pop, flush, grant_fire;
  logic [CNT_W-1:0]  count_nxt;
  logic [ENT_W-1:0]  head;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   ({req_pc, imem_rdata}),
    .pop         (pop),
    .flush       (flush),
    .valid       (id_valid),
    .head        (head),
    .count_nxt_c (count_nxt)
  );

  assign id_pc     = head[ENT_W-1 -: ADDR_W];
  assign id_instr  = head[INSTR_W-1:0];
  assign id_opcode = head[INSTR_W-1 -: OPCODE_W];
  assign pop       = id_valid && id_ready;

  // Next-state logic; a redirect flushes the buffer and overrides the handshake.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_pc_n   = req_pc;
    halted_n   = halted;
    push       = 1'b0;
    flush      = 1'b0;
    grant_fire = imem_req && imem_gnt;
    if (redirect_valid) begin
      flush    = 1'b1;
      pc_n     = redirect_pc;
      halted_n = 1'b0;
      if (imem_rvalid)                          state_n = ST_FETCH;
      else if (state != ST_FETCH || grant_fire) state_n = ST_DROP;
      else                                      state_n = ST_FETCH;
    end else begin
      unique case (state)
        ST_FETCH: if (grant_fire) begin
          pc_n     = pc + ADDR_W'(1);
          req_pc_n = pc;
          state_n  = ST_WAIT;
        end
        ST_WAIT: if (imem_rvalid) begin
          push    = 1'b1;
          state_n = ST_FETCH;
`ifdef IFETCH_HALT_EN
          if (imem_rdata[INSTR_W-1 -: OPCODE_W] == OP_HALT) halted_n = 1'b1;
`endif
        end
        ST_DROP: if (imem_rvalid) state_n = ST_FETCH;
        default: state_n = ST_FETCH;
      endcase
    end
  end

  // Request is registered from next-cycle state and occupancy only.
  assign req_n = (state_n == ST_FETCH) && (count_nxt < CNT_W'(DEPTH)) && !halted_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      req_pc    <= '0;
      halted    <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_pc    <= req_pc_n;
      halted    <= halted_n;
      imem_req  <= req_n;
      imem_addr <= pc_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a one-outstanding memory responder.
module tb_instr_fetch;

`ifdef IFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [15:0] id_instr;
  logic [3:0]  id_opcode;
  logic [7:0]  id_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic       pend = 1'b0;
  logic [7:0] pend_addr = '0;
  logic       halt_word = 1'b0;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_pc          (id_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, ready, gnt_en, rv_en, redir;
    logic [7:0] rpc;
    logic       exp_req;
    logic [7:0] exp_addr;
    logic       exp_valid;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  function automatic logic [15:0] word(input logic [7:0] a);
    if (halt_word && a == 8'h03) return 16'hF000;
    return {1'b0, a[2:0], ~a, 4'h5};
  endfunction

  function automatic vec_t mk(input logic r, ready, gnt_en, rv_en, redir, input logic [7:0] rpc,
                              input logic er, input logic [7:0] ea, input logic ev,
                              input logic [7:0] ep);
    vec_t v;
    v.rst = r; v.ready = ready; v.gnt_en = gnt_en; v.rv_en = rv_en; v.redir = redir;
    v.rpc = rpc; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, memory grants/returns data, then sample #1 after the edge.
  task automatic tick(input logic r, ready, gnt_en, rv_en, redir, input logic [7:0] rpc);
    logic       granted;
    logic [7:0] gaddr;
    rst            = r;
    id_ready       = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = gnt_en && (imem_req === 1'b1);
    imem_rvalid    = pend && rv_en;
    imem_rdata     = word(pend_addr);
    granted        = imem_gnt;
    gaddr          = imem_addr;
    @(posedge clk);
    if (imem_rvalid) pend = 1'b0;
    if (granted) begin
      pend      = 1'b1;
      pend_addr = gaddr;
    end
    #1;
  endtask

  initial begin
    logic [15:0] w;

    // main stream, back-pressure, redirects, PC wrap, mid-transaction reset
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h00,0,8'h00)); // 0 first request
    vq.push_back(mk(0,1,1,1,0,8'h00, 0,8'h01,0,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h01,1,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 0,8'h02,0,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h02,1,8'h01));
    vq.push_back(mk(0,1,1,1,0,8'h00, 0,8'h03,0,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h03,1,8'h02));
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h04,1,8'h02)); // 7 stall
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h04,1,8'h02)); // full -> no req
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h04,1,8'h02));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h04,1,8'h03)); // drain resumes fetch
    vq.push_back(mk(0,1,1,1,0,8'h00, 0,8'h05,0,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h05,1,8'h04));
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h06,1,8'h04)); // 13 grant addr 5
    vq.push_back(mk(0,0,1,0,1,8'h40, 0,8'h40,0,8'h00)); // redirect while outstanding
    vq.push_back(mk(0,0,1,1,0,8'h00, 1,8'h40,0,8'h00)); // stale data dropped
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h41,0,8'h00));
    vq.push_back(mk(0,0,1,1,0,8'h00, 1,8'h41,1,8'h40));
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h42,1,8'h40));
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h42,1,8'h40));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h42,1,8'h41));
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h43,1,8'h41));
    vq.push_back(mk(0,0,1,1,1,8'hFF, 1,8'hFF,0,8'h00)); // 22 redirect with rvalid
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h00,0,8'h00)); // pc wraps
    vq.push_back(mk(0,0,1,1,0,8'h00, 1,8'h00,1,8'hFF));
    vq.push_back(mk(0,1,1,1,0,8'h00, 0,8'h01,0,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h01,1,8'h00));
    vq.push_back(mk(0,1,1,1,1,8'h10, 0,8'h10,0,8'h00)); // 27 redirect with same-cycle grant
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h10,0,8'h00));
    vq.push_back(mk(0,1,0,1,0,8'h00, 1,8'h10,0,8'h00)); // req held without grant
    vq.push_back(mk(0,1,1,1,0,8'h00, 0,8'h11,0,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h11,1,8'h10));
    vq.push_back(mk(0,0,0,1,1,8'h20, 1,8'h20,0,8'h00)); // 32 idle redirect
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h21,0,8'h00));
    vq.push_back(mk(0,0,1,1,0,8'h00, 1,8'h21,1,8'h20));
    vq.push_back(mk(0,0,1,0,0,8'h00, 0,8'h22,1,8'h20)); // 35 grant then reset
    vq.push_back(mk(1,0,1,0,0,8'h00, 0,8'h00,0,8'h00));
    vq.push_back(mk(0,0,1,1,0,8'h00, 1,8'h00,0,8'h00)); // late rvalid ignored
    vq.push_back(mk(0,0,1,1,0,8'h00, 0,8'h01,0,8'h00));
    vq.push_back(mk(0,1,1,1,0,8'h00, 1,8'h01,1,8'h00));

    tick(1, 0, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 0, 8'h00);
    chk("reset imem_req",  32'(imem_req),  32'h0);
    chk("reset imem_addr", 32'(imem_addr), 32'h0);
    chk("reset id_valid",  32'(id_valid),  32'h0);
    chk("reset id_instr",  32'(id_instr),  32'h0);
    chk("reset id_opcode", 32'(id_opcode), 32'h0);
    chk("reset id_pc",     32'(id_pc),     32'h0);
    chk("reset halted",    32'(halted),    32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].rst, vq[i].ready, vq[i].gnt_en, vq[i].rv_en, vq[i].redir, vq[i].rpc);
      chk($sformatf("row%0d imem_req", i),  32'(imem_req),  32'(vq[i].exp_req));
      chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(vq[i].exp_addr));
      chk($sformatf("row%0d id_valid", i),  32'(id_valid),  32'(vq[i].exp_valid));
      chk($sformatf("row%0d halted", i),    32'(halted),    32'h0);
      if (vq[i].exp_valid) begin
        w = word(vq[i].exp_pc);
        chk($sformatf("row%0d id_pc", i),     32'(id_pc),     32'(vq[i].exp_pc));
        chk($sformatf("row%0d id_instr", i),  32'(id_instr),  32'(w));
        chk($sformatf("row%0d id_opcode", i), 32'(id_opcode), 32'(w[15:12]));
      end
    end

    // opcode F at addr 3: halts only when the feature is built in
    tick(0, 0, 0, 1, 1, 8'h03);
    chk("h0 imem_req",  32'(imem_req),  32'h1);
    chk("h0 imem_addr", 32'(imem_addr), 32'h03);
    halt_word = 1'b1;
    tick(0, 0, 1, 1, 0, 8'h00);
    chk("h1 imem_req",  32'(imem_req),  32'h0);
    tick(0, 0, 1, 1, 0, 8'h00);
    chk("h2 id_valid",  32'(id_valid),  32'h1);
    chk("h2 id_pc",     32'(id_pc),     32'h03);
    chk("h2 id_instr",  32'(id_instr),  32'hF000);
    chk("h2 id_opcode", 32'(id_opcode), 32'hF);
    chk("h2 halted",    32'(halted),    32'(HALT_EN));
    chk("h2 imem_req",  32'(imem_req),  32'(!HALT_EN));
    chk("h2 imem_addr", 32'(imem_addr), 32'h04);
    for (int k = 3; k < 5; k++) begin
      tick(0, 1, 0, 1, 0, 8'h00);
      chk($sformatf("h%0d id_valid", k), 32'(id_valid), 32'h0);
      chk($sformatf("h%0d halted", k),   32'(halted),   32'(HALT_EN));
      chk($sformatf("h%0d imem_req", k), 32'(imem_req), 32'(!HALT_EN));
    end
    tick(0, 0, 0, 1, 1, 8'h00);
    chk("h5 halted",    32'(halted),    32'h0);
    chk("h5 imem_req",  32'(imem_req),  32'h1);
    chk("h5 imem_addr", 32'(imem_addr), 32'h00);
    tick(0, 0, 1, 1, 0, 8'h00);
    chk("h6 imem_req",  32'(imem_req),  32'h0);
    chk("h6 imem_addr", 32'(imem_addr), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
